// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register.
// Provides the stage state encoding and the per-stage control widths
// with their bubble constants.
package pipe_pkg;

  // The state code doubles as the occupancy count (0, 1 or 2 entries).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Per-stage control widths and the control value carried by a bubble.
  localparam int          IF_ID_CTRL_W  = 4;
  localparam logic [3:0]  IF_ID_BUBBLE  = 4'h0;
  localparam int          ID_EX_CTRL_W  = 8;
  localparam logic [7:0]  ID_EX_BUBBLE  = 8'h00;
  localparam int          EX_MEM_CTRL_W = 5;
  localparam logic [4:0]  EX_MEM_BUBBLE = 5'h00;
  localparam int          MEM_WB_CTRL_W = 2;
  localparam logic [1:0]  MEM_WB_BUBBLE = 2'h0;

endpackage

// File: rtl/pipe_stage_entry.sv
// Purpose: one DATA_W+CTRL_W holding register (main or skid slot of a stage).
// Latency: 1 cycle from i_load to o_data/o_ctrl; no handshake of its own.
// Ports: clk/arst_n; i_load captures i_data/i_ctrl; i_clr_ctrl forces ctrl to
//        CTRL_BUBBLE (wins over i_load, data untouched); o_data/o_ctrl stored entry.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 8,
  parameter logic [63:0]       PRESET_VAL  = 64'd0,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_load,
  input  logic              i_clr_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_data <= DATA_W'(PRESET_VAL);
      r_ctrl <= CTRL_W'(PRESET_VAL);
    end else if (i_clr_ctrl) begin
      // A flushed slot must never carry live control; data is left as-is.
      r_ctrl <= CTRL_BUBBLE;
    end else if (i_load) begin
      r_data <= i_data;
      r_ctrl <= i_ctrl;
    end
  end

  assign o_data = r_data;
  assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Purpose: generic valid/ready pipeline-stage register with optional 2-entry skid.
// Latency: 1 cycle in_fire -> out_valid; 1 entry/cycle sustained throughput.
// Backpressure: SKID=1 registered in_ready (low only when FULL); SKID=0 in_ready = !out_valid | out_ready.
// Ports: in_* upstream handshake, out_* downstream handshake, flush kills held
//        entries, occupancy = entries held, stall_cnt/stall_clr saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 8,
  parameter logic [63:0]       PRESET_VAL  = 64'd0,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                SKID        = 1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_ld_main;
  logic              w_ld_skid;
  logic              w_main_from_skid;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and slot load decode; flush overrides everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_ld_main        = 1'b0;
    w_ld_skid        = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_ld_main   = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_ld_main = 1'b1;
          end else if (w_in_fire && (SKID != 0)) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_ld_main        = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Saturating stall counter; clear beats increment, flush leaves it alone.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  pipe_stage_entry #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .PRESET_VAL  (PRESET_VAL),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_main (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_load     (w_ld_main),
    .i_clr_ctrl (flush),
    .i_data     (w_main_from_skid ? w_skid_data : in_data),
    .i_ctrl     (w_main_from_skid ? w_skid_ctrl : in_ctrl),
    .o_data     (w_main_data),
    .o_ctrl     (w_main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;

      pipe_stage_entry #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .PRESET_VAL  (PRESET_VAL),
        .CTRL_BUBBLE (CTRL_BUBBLE)
      ) u_skid (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_load     (w_ld_skid),
        .i_clr_ctrl (flush),
        .i_data     (in_data),
        .i_ctrl     (in_ctrl),
        .o_data     (w_skid_data),
        .o_ctrl     (w_skid_ctrl)
      );

      // Derived from next state so out_ready has no combinational path to in_ready.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_in_ready <= 1'b1;
        else         r_in_ready <= (w_state_nxt != ST_FULL);
      end
      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      logic w_unused_ld_skid;
      assign w_unused_ld_skid = w_ld_skid;
      assign w_skid_data      = '0;
      assign w_skid_ctrl      = '0;
      assign w_in_ready       = !r_out_valid | out_ready;
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_data;
  assign out_ctrl  = r_out_valid ? w_main_ctrl : CTRL_BUBBLE;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  // DUT A: skid version, small stall counter
  logic        a_iv, a_ir, a_ov, a_ordy, a_fl, a_clr;
  logic [63:0] a_id, a_od;
  logic [7:0]  a_ic, a_oc;
  logic [1:0]  a_occ;
  logic [3:0]  a_st;

  // DUT B: single-register version
  logic        b_iv, b_ir, b_ov, b_ordy;
  logic [63:0] b_id, b_od;
  logic [7:0]  b_ic, b_oc;
  logic [1:0]  b_occ;
  logic [15:0] b_st;

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .PRESET_VAL(64'hDEAD),
                    .CTRL_BUBBLE(8'hEE), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .arst_n(arst_n), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .in_ctrl(a_ic), .out_valid(a_ov), .out_ready(a_ordy),
    .out_data(a_od), .out_ctrl(a_oc), .flush(a_fl), .occupancy(a_occ),
    .stall_cnt(a_st), .stall_clr(a_clr));

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .PRESET_VAL(64'hDEAD),
                    .CTRL_BUBBLE(8'hEE), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .arst_n(arst_n), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .in_ctrl(b_ic), .out_valid(b_ov), .out_ready(b_ordy),
    .out_data(b_od), .out_ctrl(b_oc), .flush(1'b0), .occupancy(b_occ),
    .stall_cnt(b_st), .stall_clr(1'b0));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic [7:0]  c;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic        e_ov;
    logic [63:0] e_od;
    logic [7:0]  e_oc;
    logic [1:0]  e_occ;
    logic        e_ir;
    logic [3:0]  e_st;
  } vec_t;

  vec_t vt[13];

  logic        m_valid;
  logic [63:0] m_data;
  logic [63:0] next_d;
  logic        inf, outf;

  initial begin
    // Inputs / expected state after the following clock edge
    vt[0]  = '{1'b1, 64'h1234, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1234, 8'h5A, 2'd1, 1'b1, 4'd0};
    vt[1]  = '{1'b1, 64'hA0,   8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA0,   8'h01, 2'd1, 1'b1, 4'd0};
    vt[2]  = '{1'b1, 64'hA1,   8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 64'hA0,   8'h01, 2'd2, 1'b0, 4'd1};
    vt[3]  = '{1'b1, 64'hA2,   8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 64'hA0,   8'h01, 2'd2, 1'b0, 4'd2};
    vt[4]  = '{1'b1, 64'hA2,   8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA1,   8'h02, 2'd1, 1'b1, 4'd2};
    vt[5]  = '{1'b1, 64'hA2,   8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA2,   8'h03, 2'd1, 1'b1, 4'd2};
    vt[6]  = '{1'b0, 64'h0,    8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 64'hA2,   8'hEE, 2'd0, 1'b1, 4'd2};
    vt[7]  = '{1'b1, 64'hB0,   8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 64'hB0,   8'h11, 2'd1, 1'b1, 4'd2};
    vt[8]  = '{1'b1, 64'hB1,   8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 64'hB0,   8'h11, 2'd2, 1'b0, 4'd3};
    vt[9]  = '{1'b1, 64'hB2,   8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 64'hB0,   8'hEE, 2'd0, 1'b1, 4'd4};
    vt[10] = '{1'b0, 64'h0,    8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 64'hB0,   8'hEE, 2'd0, 1'b1, 4'd4};
    vt[11] = '{1'b1, 64'hC0,   8'h21, 1'b1, 1'b0, 1'b0, 1'b1, 64'hC0,   8'h21, 2'd1, 1'b1, 4'd4};
    vt[12] = '{1'b0, 64'h0,    8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 64'hC0,   8'hEE, 2'd0, 1'b1, 4'd0};

    arst_n = 1'b0;
    a_iv = 0; a_id = '0; a_ic = '0; a_ordy = 0; a_fl = 0; a_clr = 0;
    b_iv = 0; b_id = '0; b_ic = '0; b_ordy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ov", {63'd0, a_ov}, 64'd0);
    chk("rst ir", {63'd0, a_ir}, 64'd1);
    chk("rst occ", {62'd0, a_occ}, 64'd0);
    chk("rst stall", {60'd0, a_st}, 64'd0);
    chk("rst od", a_od, 64'hDEAD);
    chk("rst oc", {56'd0, a_oc}, 64'hEE);
    chk("rst b ir", {63'd0, b_ir}, 64'd1);
    @(negedge clk);
    arst_n = 1'b1;

    // Table: first transfer, skid fill/drain, flush while FULL, stall clear
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      a_iv = vt[i].iv; a_id = vt[i].d; a_ic = vt[i].c;
      a_ordy = vt[i].ordy; a_fl = vt[i].fl; a_clr = vt[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ov", i), {63'd0, a_ov}, {63'd0, vt[i].e_ov});
      chk($sformatf("v%0d od", i), a_od, vt[i].e_od);
      chk($sformatf("v%0d oc", i), {56'd0, a_oc}, {56'd0, vt[i].e_oc});
      chk($sformatf("v%0d occ", i), {62'd0, a_occ}, {62'd0, vt[i].e_occ});
      chk($sformatf("v%0d ir", i), {63'd0, a_ir}, {63'd0, vt[i].e_ir});
      chk($sformatf("v%0d stall", i), {60'd0, a_st}, {60'd0, vt[i].e_st});
    end

    // Stall counter saturation at 15, then clear
    @(negedge clk);
    a_iv = 1; a_id = 64'hE0; a_ic = 8'h31; a_ordy = 0; a_clr = 0;
    @(negedge clk);
    a_iv = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("sat stall", {60'd0, a_st}, 64'd15);
    chk("sat od hold", a_od, 64'hE0);
    chk("sat oc hold", {56'd0, a_oc}, 64'h31);
    @(negedge clk);
    a_clr = 1;
    @(posedge clk);
    #1;
    chk("clr stall", {60'd0, a_st}, 64'd0);

    // SKID=0: out_ready toggles with continuous input, reference model
    m_valid = 1'b0; m_data = '0; next_d = 64'h100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_ordy = (i % 2 == 0); b_iv = 1; b_id = next_d; b_ic = next_d[7:0];
      #1;
      chk($sformatf("b%0d ir", i), {63'd0, b_ir}, {63'd0, (!m_valid | b_ordy)});
      chk($sformatf("b%0d ov", i), {63'd0, b_ov}, {63'd0, m_valid});
      if (m_valid) chk($sformatf("b%0d od", i), b_od, m_data);
      inf  = b_iv & (!m_valid | b_ordy);
      outf = m_valid & b_ordy;
      @(posedge clk);
      if (inf) begin
        m_valid = 1'b1; m_data = b_id; next_d = next_d + 1;
      end else if (outf) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    b_iv = 0; b_ordy = 0;

    // Fill A to FULL, then asynchronous reset between clock edges
    a_clr = 0; a_iv = 1; a_id = 64'hE1; a_ic = 8'h32; a_ordy = 0;
    @(posedge clk);
    #1;
    chk("pre-rst occ", {62'd0, a_occ}, 64'd2);
    chk("pre-rst ir", {63'd0, a_ir}, 64'd0);
    @(negedge clk);
    a_iv = 0;
    #2 arst_n = 1'b0;
    #1;
    chk("arst ov", {63'd0, a_ov}, 64'd0);
    chk("arst stall", {60'd0, a_st}, 64'd0);
    chk("arst od", a_od, 64'hDEAD);
    chk("arst occ", {62'd0, a_occ}, 64'd0);
    chk("arst oc", {56'd0, a_oc}, 64'hEE);
    chk("arst ir", {63'd0, a_ir}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic parametrised pipeline-stage register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data field and a control field under a valid/ready handshake.
- Optional 2-entry skid buffer gives full throughput with a registered in_ready.
- Synchronous flush inserts a bubble: control forced to a bubble value, valid cleared.
- A saturating stall counter supports performance debug.

Parameters:
DATA_W, 64, width of data payload (operands, immediates, PC)
CTRL_W, 8, width of control payload (writeback, memread, memwrite, alusrc, aluop, ...)
PRESET_VAL, 0, reset value of stored data and control fields
CTRL_BUBBLE, 0, control value presented when stage holds no valid entry
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept
in_data  in  DATA_W  upstream data
in_ctrl  in  CTRL_W  upstream control
out_valid  out  1  stage presents valid entry
out_ready  in  1  downstream accepts
out_data  out  DATA_W  head entry data
out_ctrl  out  CTRL_W  head entry control, CTRL_BUBBLE when out_valid=0
flush  in  1  synchronous kill of all held entries
occupancy  out  2  entries held (0..2)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
stall_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset, via arst_n=0 asynchronously:
  - state EMPTY, out_valid=0, occupancy=0, stall_cnt=0.
  - Main and skid data/ctrl = PRESET_VAL.
  - in_ready=1.
  - out_ctrl=CTRL_BUBBLE.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_valid need not be held by upstream.
  - out_data/out_ctrl stay stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput 1 entry/cycle in steady state.
- State machine for SKID=1 (EMPTY / ONE / FULL):
  - EMPTY: in_fire -> main<=in, ONE.
  - ONE:
    - in_fire & out_fire -> main<=in, stay ONE.
    - in_fire & !out_fire -> skid<=in, FULL.
    - !in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - FULL: out_fire -> main<=skid, ONE; else hold.
  - in_ready is a register, 0 only in FULL (next-state based, no combinational path from out_ready).
- SKID=0:
  - States EMPTY/ONE only; no skid storage.
  - in_ready = !out_valid | out_ready (combinational).
  - Simultaneous in_fire & out_fire replaces main.
- Flush has highest priority:
  - Next state EMPTY, occupancy 0, in_ready 1 the next cycle.
  - Stored ctrl <= CTRL_BUBBLE; data fields keep their values.
  - Any in_fire in the same cycle is discarded; upstream is flushed by the same hazard unit.
  - An out_fire in the flush cycle still counts as consumed downstream.
- out_ctrl = out_valid ? main_ctrl : CTRL_BUBBLE, so a bubble never carries writeback or memwrite.
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - stall_clr has priority over increment.
  - Flush does not clear it.
- Reset mid-operation: all held entries are lost, no partial outputs. Deassertion is synchronised externally.

Decomposition:
- Shared package pipe_pkg:
  - State encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Per-stage CTRL_W constants and bubble constants, e.g. ID_EX_CTRL_W, ID_EX_BUBBLE.
- One sub-module, pipe_stage_entry: DATA_W+CTRL_W holding register with load enable and ctrl-clear input, instantiated for main and skid (skid instance generated only when SKID=1).

Test Plan:
- Reset, then in_valid=1, in_data=64'h1234, in_ctrl=8'h5A, out_ready=1 -> next cycle out_valid=1, out_data=64'h1234, out_ctrl=8'h5A, occupancy=1.
- SKID=1, stream D0,D1,D2, out_ready=0 from cycle 1 -> D0 held at output, D1 in skid, in_ready=0, occupancy=2, D2 not accepted; out_ready=1 -> D0, D1, D2 emitted in order, no loss or duplication.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0, in_ready=1; the flushed-cycle input never appears.
- SKID=0, out_ready toggling 1,0,1,0 with continuous input -> in_ready equals !out_valid|out_ready each cycle; output order preserved.
- CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15; stall_clr=1 -> 0 next cycle.
- arst_n pulsed low while FULL -> out_valid=0, stall_cnt=0, out_data=PRESET_VAL immediately without a clock edge.
